// File: rtl/aes_inv_round_iter.sv
// Iterative AES-128 inverse round: InvShiftRows, InvSubBytes, AddRoundKey, InvMixColumns, one column per cycle.
// Build option: define INV_ROUND_KEY_LATCH_EN to capture key_in at acceptance instead of sampling it during MIX.
module aes_inv_round_iter #(
  parameter int NB  = 4,
  parameter int LAT = 8
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] data_in,
  input  logic [127:0] key_in,
  input  logic         last_round,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] data_out
);

  if (NB != 4 || LAT != 2 * NB) begin : g_param_check
    $error("aes_inv_round_iter: NB must be 4 and LAT must equal 2*NB");
  end

  typedef enum logic [1:0] {IDLE, SUB, MIX, DONE} state_t;

  state_t       r_state;
  state_t       w_state_next;
  logic [127:0] r_st;
  logic [1:0]   r_col;
  logic         r_last;
  logic         r_out_valid;
  logic [127:0] r_data_out;
  logic [127:0] w_key;
  logic [127:0] w_isr;
  logic [127:0] w_st_next;
  logic [31:0]  w_cols [4];
  logic [31:0]  w_key_cols [4];
  logic [31:0]  w_col;
  logic [31:0]  w_key_col;
  logic [31:0]  w_sub_col;
  logic [31:0]  w_ark;
  logic [31:0]  w_mix;
  logic [31:0]  w_new_col;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // x^254 equals x^-1 in GF(2^8) and conveniently maps 0 to 0.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] p;
    logic [7:0] r;
    p = a;
    r = 8'h01;
    for (int i = 0; i < 7; i++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    logic [7:0] t;
    for (int i = 0; i < 8; i++) begin
      t[i] = b[(i + 2) % 8] ^ b[(i + 5) % 8] ^ b[(i + 7) % 8];
    end
    return gf_inv(t ^ 8'h05);
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
            gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
            gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
            gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)};
  endfunction

`ifdef INV_ROUND_KEY_LATCH_EN
  logic [127:0] r_key;
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_key <= '0;
    end else if (r_state == IDLE && in_valid) begin
      r_key <= key_in;
    end
  end
  assign w_key = r_key;
`else
  assign w_key = key_in;
`endif

  // Byte gi is s(r,c) with r = gi%4, c = gi/4; row r rotates right by r.
  for (genvar gi = 0; gi < 16; gi++) begin : g_isr
    localparam int R  = gi % 4;
    localparam int C  = gi / 4;
    localparam int CS = (C - R + 4) % 4;
    assign w_isr[127 - 8 * gi -: 8] = data_in[127 - 8 * (4 * CS + R) -: 8];
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_cols
    assign w_cols[gi]     = r_st[127 - 32 * gi -: 32];
    assign w_key_cols[gi] = w_key[127 - 32 * gi -: 32];
    assign w_st_next[127 - 32 * gi -: 32] = (r_col == 2'(gi)) ? w_new_col : w_cols[gi];
  end

  assign w_col     = w_cols[r_col];
  assign w_key_col = w_key_cols[r_col];

  for (genvar gi = 0; gi < 4; gi++) begin : g_sbox
    assign w_sub_col[31 - 8 * gi -: 8] = inv_sbox(w_col[31 - 8 * gi -: 8]);
  end

  assign w_ark     = w_col ^ w_key_col;
  assign w_mix     = inv_mix_col(w_ark);
  assign w_new_col = (r_state == SUB) ? w_sub_col : (r_last ? w_ark : w_mix);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (in_valid) w_state_next = SUB;
      SUB:     if (r_col == 2'd3) w_state_next = MIX;
      MIX:     if (r_col == 2'd3) w_state_next = DONE;
      DONE:    if (out_ready) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_st        <= '0;
      r_col       <= 2'd0;
      r_last      <= 1'b0;
      r_out_valid <= 1'b0;
      r_data_out  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_st   <= w_isr;
            r_last <= last_round;
            r_col  <= 2'd0;
          end
        end
        SUB: begin
          r_st  <= w_st_next;
          r_col <= r_col + 2'd1;
        end
        MIX: begin
          r_st  <= w_st_next;
          r_col <= r_col + 2'd1;
          if (r_col == 2'd3) begin
            r_data_out  <= w_st_next;
            r_out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) r_out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = r_out_valid;
  assign data_out  = r_data_out;

endmodule

// File: tb/tb_aes_inv_round_iter.sv
// Directed and randomized checks of aes_inv_round_iter against a table-driven inverse-round model.
module tb_aes_inv_round_iter;

  logic         CLK = 1'b0;
  logic         RST = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] data_in = '0;
  logic [127:0] key_in = '0;
  logic         last_round = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [127:0] data_out;

  int tests = 0;
  int fails = 0;
  logic [7:0] inv_tab [256];

  aes_inv_round_iter dut (
    .CLK(CLK), .RST(RST),
    .in_valid(in_valid), .in_ready(in_ready),
    .data_in(data_in), .key_in(key_in), .last_round(last_round),
    .out_valid(out_valid), .out_ready(out_ready), .data_out(data_out)
  );

  always #5 CLK = ~CLK;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  // Forward S-box by brute-force inverse search, then invert the table.
  task automatic build_tables();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv = 8'h00;
      logic [7:0] s;
      for (int y = 1; y < 256; y++)
        if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
      inv_tab[s] = 8'(x);
    end
  endtask

  function automatic logic [127:0] ref_round(input logic [127:0] d, input logic [127:0] k, input bit last);
    logic [7:0] s [4][4];
    logic [7:0] t [4][4];
    logic [7:0] m [4][4];
    logic [7:0] coef [4] = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
    logic [127:0] res;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        s[r][c] = d[127 - 8 * (4 * c + r) -: 8];
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        t[r][(c + r) % 4] = inv_tab[s[r][c]] ^ k[127 - 8 * (4 * ((c + r) % 4) + r) -: 8];
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        m[r][c] = 8'h00;
        for (int j = 0; j < 4; j++) m[r][c] = m[r][c] ^ gmul(coef[(j - r + 4) % 4], t[j][c]);
        if (last) m[r][c] = t[r][c];
      end
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        res[127 - 8 * (4 * c + r) -: 8] = m[r][c];
    return res;
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic accept(input logic [127:0] d, input logic [127:0] k, input bit last);
    int n = 0;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    check("accept_ready", 128'(in_ready), 128'(1));
    data_in = d; key_in = k; last_round = last; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("busy_in_ready", 128'(in_ready), 128'(0));
  endtask

  task automatic wait_out(input string tag, input bit chg_key);
    int lat = 0;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
      if (chg_key && lat == 1) key_in = '1;
    end
    check({tag, "_latency"}, 128'(lat), 128'(8));
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("release_valid", 128'(out_valid), 128'(0));
    check("release_ready", 128'(in_ready), 128'(1));
  endtask

  task automatic run_block(input string tag, input logic [127:0] d, input logic [127:0] k, input bit last);
    accept(d, k, last);
    wait_out(tag, 1'b0);
    check(tag, data_out, ref_round(d, k, last));
    $display("[TB] %s data_in=%h key=%h last=%0d data_out=%h", tag, d, k, last, data_out);
    release_out();
  endtask

  localparam logic [127:0] C1_IN  = 128'h6353e08c0960e104cd70b751bacad0e7;
  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_OUT = 128'h00112233445566778899aabbccddeeff;

  initial begin
    logic [127:0] d;
    logic [127:0] k;
    logic [127:0] held;
    logic [127:0] d2;
    build_tables();

    #1 RST = 1'b1;
    #2;
    check("rst_in_ready", 128'(in_ready), 128'(1));
    check("rst_out_valid", 128'(out_valid), 128'(0));
    check("rst_data_out", data_out, 128'h0);
    tick(); tick();
    RST = 1'b0;
    tick();

    accept('0, '0, 1'b0);
    wait_out("zero", 1'b0);
    check("zero_const", data_out, {16{8'h52}});
    release_out();

    accept({16{8'h63}}, {16{8'hff}}, 1'b0);
    wait_out("x63", 1'b0);
    check("x63_const", data_out, {16{8'hff}});
    release_out();

    accept(C1_IN, C1_KEY, 1'b1);
    wait_out("c1", 1'b0);
    check("c1_const", data_out, C1_OUT);
    check("c1_model", data_out, ref_round(C1_IN, C1_KEY, 1'b1));
    release_out();

    for (int i = 0; i < 6; i++) begin
      d = {$urandom, $urandom, $urandom, $urandom};
      k = {$urandom, $urandom, $urandom, $urandom};
      run_block("rand", d, k, 1'($urandom_range(0, 1)));
    end

    // Backpressure: hold out_ready low while a second block knocks.
    d = {$urandom, $urandom, $urandom, $urandom};
    k = {$urandom, $urandom, $urandom, $urandom};
    accept(d, k, 1'b0);
    wait_out("bp", 1'b0);
    held = data_out;
    check("bp_data", held, ref_round(d, k, 1'b0));
    d2 = {$urandom, $urandom, $urandom, $urandom};
    data_in = d2; last_round = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_hold_data", data_out, held);
      check("bp_hold_valid", 128'(out_valid), 128'(1));
      check("bp_hold_ready", 128'(in_ready), 128'(0));
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bp_release_valid", 128'(out_valid), 128'(0));
    check("bp_release_ready", 128'(in_ready), 128'(1));
    check("bp_data_kept", data_out, held);
    tick();
    in_valid = 1'b0;
    check("bp_second_accepted", 128'(in_ready), 128'(0));
    wait_out("bp2", 1'b0);
    check("bp2_data", data_out, ref_round(d2, k, 1'b1));
    $display("[TB] backpressure second block data_out=%h", data_out);
    release_out();

    // Reset in the middle of SUB.
    accept(C1_IN, C1_KEY, 1'b0);
    tick(); tick(); tick();
    RST = 1'b1;
    #1;
    check("midrst_out_valid", 128'(out_valid), 128'(0));
    check("midrst_data_out", data_out, 128'h0);
    check("midrst_in_ready", 128'(in_ready), 128'(1));
    tick();
    RST = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("midrst_no_output", 128'(out_valid), 128'(0));
    end
    run_block("after_rst", C1_IN, C1_KEY, 1'b1);
    check("after_rst_const", ref_round(C1_IN, C1_KEY, 1'b1), C1_OUT);

`ifdef INV_ROUND_KEY_LATCH_EN
    accept(C1_IN, C1_KEY, 1'b1);
    wait_out("keylatch", 1'b1);
    check("keylatch_data", data_out, C1_OUT);
    $display("[TB] keylatch data_out=%h", data_out);
    release_out();
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
